calc_atan_sector_15: RTL

//  Inverse of the r*tan(15n) table: takes a signed (x,y) offset and returns the

---
 rtl/calc_atan_sector_15.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/calc_atan_sector_15.sv
// calc_atan_sector_15
//   Sequential quantised atan: converts a signed (x,y) offset into a polar
//   angle in 15-degree steps (0..23, CCW from +x). The request is folded into
//   quadrant 1, then |y| is compared against |x|*tan(boundary) one boundary
//   per cycle, with an early exit on the first boundary not reached.
//
// Ports
//   clock    in   system clock
//   reset_n  in   synchronous active-low reset
//   start    in   request pulse, sampled only in IDLE
//   x_in     in   signed x offset (W_IN bits)
//   y_in     in   signed y offset (W_IN bits)
//   busy     out  high during FOLD and CMP
//   done     out  one-cycle pulse, angle/zero valid
//   angle    out  result in 15-degree units, held until the next done
//   zero     out  x==0 && y==0 (angle forced to 0), held with angle
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; x_in/y_in captured on start
// FOLD  | absolute values and sign flags of the captured offset
// CMP   | one tan-boundary comparison per cycle, k = boundaries passed
// DONE  | done pulse; angle/zero already loaded on entry
module calc_atan_sector_15 #(
    parameter int W_IN = 9,
    parameter int FRAC = 11
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic signed [W_IN-1:0] x_in,
    input  logic signed [W_IN-1:0] y_in,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             angle,
    output logic                   zero
);

    // |x| <= 2^(W_IN-1) and K < 2^14, so W_IN+15 bits hold every product.
    localparam int PW = W_IN + 15;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FOLD = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]             state_q, state_d;
    logic signed [W_IN-1:0] x_q, x_d;
    logic signed [W_IN-1:0] y_q, y_d;
    logic [W_IN-1:0]        ax_q, ax_d;
    logic [W_IN-1:0]        ay_q, ay_d;
    logic                   sx_q, sx_d;
    logic                   sy_q, sy_d;
    logic [2:0]             i_q, i_d;
    logic [2:0]             k_q, k_d;
    logic [4:0]             angle_q, angle_d;
    logic                   zero_q, zero_d;

    logic [W_IN-1:0]        x_u, y_u;
    logic [W_IN-1:0]        abs_x, abs_y;
    logic [13:0]            k_const;
    logic [PW-1:0]          lhs, prod;
    logic                   hit;
    logic [2:0]             k_fin;
    logic [4:0]             kk;
    logic [4:0]             sector;

    // Unsigned W_IN-bit magnitude: the most negative input maps to 2^(W_IN-1)
    // exactly, since the result is read back as unsigned.
    assign x_u   = x_q;
    assign y_u   = y_q;
    assign abs_x = x_u[W_IN-1] ? (~x_u + W_IN'(1)) : x_u;
    assign abs_y = y_u[W_IN-1] ? (~y_u + W_IN'(1)) : y_u;

    // tan() of the odd 7.5-degree boundaries, Q.11
    always_comb begin
        k_const = 14'd15556;
        case (i_q)
            3'd0:    k_const = 14'd270;
            3'd1:    k_const = 14'd848;
            3'd2:    k_const = 14'd1571;
            3'd3:    k_const = 14'd2669;
            3'd4:    k_const = 14'd4944;
            default: k_const = 14'd15556;
        endcase
    end

    // Ties count as reaching the boundary, so the angle rounds up.
    assign lhs  = {{(PW-W_IN){1'b0}}, ay_q} << FRAC;
    assign prod = {{(PW-W_IN){1'b0}}, ax_q} * {{(PW-14){1'b0}}, k_const};
    assign hit  = (lhs >= prod);

    // Quadrant unfold of the final k (value k will hold after this CMP cycle).
    assign k_fin = hit ? (i_q + 3'd1) : k_q;
    assign kk    = {2'b00, k_fin};

    always_comb begin
        sector = kk;
        case ({sx_q, sy_q})
            2'b00:   sector = kk;
            2'b10:   sector = 5'd12 - kk;
            2'b11:   sector = 5'd12 + kk;
            default: sector = (kk == 5'd0) ? 5'd0 : (5'd24 - kk);
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        i_d     = i_q;
        k_d     = k_q;
        angle_d = angle_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                ax_d    = abs_x;
                ay_d    = abs_y;
                sx_d    = x_q[W_IN-1];
                sy_d    = y_q[W_IN-1];
                i_d     = 3'd0;
                k_d     = 3'd0;
                state_d = S_CMP;
            end
            S_CMP: begin
                if (hit) begin
                    k_d = i_q + 3'd1;
                end
                if (!hit || (i_q == 3'd5)) begin
                    // Results are loaded on entry to DONE so they are valid
                    // in the same cycle as the done pulse.
                    zero_d  = (ax_q == '0) && (ay_q == '0);
                    angle_d = ((ax_q == '0) && (ay_q == '0)) ? 5'd0 : sector;
                    state_d = S_DONE;
                end else begin
                    i_d = i_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            i_q     <= '0;
            k_q     <= '0;
            angle_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            i_q     <= i_d;
            k_q     <= k_d;
            angle_q <= angle_d;
            zero_q  <= zero_d;
        end
    end

    assign busy  = (state_q == S_FOLD) || (state_q == S_CMP);
    assign done  = (state_q == S_DONE);
    assign angle = angle_q;
    assign zero  = zero_q;

endmodule
